// File: rtl/sbox_init_pkg.sv
// sbox_init_pkg
// Shared types for the S-box initialisation sequencer:
//   mode_e  - fill pattern selected at start (RSVD behaves as IDENTITY)
//   state_e - sequencer FSM states
package sbox_init_pkg;

  typedef enum logic [1:0] {
    IDENTITY = 2'd0,
    REVERSE  = 2'd1,
    FILL     = 2'd2,
    RSVD     = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/sbox_init_ctr.sv
// sbox_init_ctr
// Write-address counter for the S-box initialisation sequencer.
// Ports:
//   clk         - clock, rising edge
//   reset_n     - synchronous active-low reset, clears the count
//   i_load_zero - restart the count at 0 (start accepted or pass aborted)
//   i_en        - a write happened this cycle; advance the count
//   o_cnt       - current write address
//   o_tc        - terminal count: o_cnt == DEPTH-1
module sbox_init_ctr #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_load_zero,
  input  logic              i_en,
  output logic [ADDR_W-1:0] o_cnt,
  output logic              o_tc
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] r_cnt;

  // Saturates at LAST so the address parks at DEPTH-1 once the pass completes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_load_zero) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + ADDR_W'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == LAST);

endmodule

// File: rtl/sbox_init_seq.sv
// sbox_init_seq
// Writes DEPTH words (addresses 0..DEPTH-1, ascending) into a memory through
// an arbitrated write port, with data chosen by the mode latched at start.
// Ports:
//   clk, reset_n        - clock (rising edge), synchronous active-low reset
//   start               - request one pass (accepted in IDLE or DONE only)
//   mode, fill_value    - pattern select and FILL constant, sampled with start
//   grant               - arbiter allows a write this cycle (may stall forever)
//   abort               - cancel an active pass, wins over grant
//   addr, wrdata, wren  - memory write port
//   busy                - pass in progress
//   done                - last pass completed, held until next start or reset
module sbox_init_seq
  import sbox_init_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] fill_value,
  input  logic              grant,
  input  logic              abort,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wrdata,
  output logic              wren,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_e              r_state;
  state_e              w_next;
  mode_e               r_mode;
  logic [DATA_W-1:0]   r_fill;
  logic                w_accept;
  logic                w_abort_wr;
  logic                w_wren;
  logic                w_busy;
  logic                w_done;
  logic                w_tc;
  logic [ADDR_W-1:0]   w_addr;

  function automatic logic [DATA_W-1:0] pattern(input mode_e m,
                                                input logic [ADDR_W-1:0] a,
                                                input logic [DATA_W-1:0] f);
    case (m)
      REVERSE: return DATA_W'(LAST - a);
      FILL:    return f;
      default: return DATA_W'(a);
    endcase
  endfunction

  assign w_accept   = ((r_state == IDLE) || (r_state == DONE)) && start;
  assign w_abort_wr = (r_state == WRITE) && abort;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Pattern inputs are only captured when a start is accepted, so a start
  // arriving mid-pass cannot disturb the data of the pass in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mode <= IDENTITY;
      r_fill <= '0;
    end else if (w_accept) begin
      r_mode <= mode_e'(mode);
      r_fill <= fill_value;
    end
  end

  always_comb begin
    w_next = r_state;
    w_wren = 1'b0;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = WRITE;
      end
      WRITE: begin
        w_busy = 1'b1;
        // reset_n gating keeps a reset cycle from committing one more word.
        w_wren = grant && !abort && reset_n;
        if (abort) begin
          w_next = IDLE;
        end else if (grant && w_tc) begin
          w_next = DONE;
        end
      end
      DONE: begin
        w_done = 1'b1;
        if (start) w_next = WRITE;
      end
      default: w_next = IDLE;
    endcase
  end

  sbox_init_ctr #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ctr (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_load_zero (w_accept || w_abort_wr),
    .i_en        (w_wren),
    .o_cnt       (w_addr),
    .o_tc        (w_tc)
  );

  assign addr   = w_addr;
  assign wrdata = pattern(r_mode, w_addr, r_fill);
  assign wren   = w_wren;
  assign busy   = w_busy;
  assign done   = w_done;

endmodule

// File: doc/sbox_init_seq.md
SBOX_INIT_SEQ -- requirements
Module: sbox_init_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: memory address width.
REQ-002 SHALL have parameter DATA_W, default 8: memory data width.
REQ-003 SHALL have parameter DEPTH, default 2**ADDR_W: words written per pass; legal range 2..2**ADDR_W.
REQ-004 SHALL have port clk, input, 1: clock; all logic on rising edge.
REQ-005 SHALL have port reset_n, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port start, input, 1: request one initialisation pass.
REQ-007 SHALL have port mode, input, 2: fill pattern, sampled with start.
REQ-008 SHALL have port fill_value, input, DATA_W: constant for FILL mode, sampled with start.
REQ-009 SHALL have port grant, input, 1: memory arbiter permits a write this cycle.
REQ-010 SHALL have port abort, input, 1: cancel an active pass.
REQ-011 SHALL have port addr, output, ADDR_W: write address.
REQ-012 SHALL have port wrdata, output, DATA_W: write data.
REQ-013 SHALL have port wren, output, 1: write strobe.
REQ-014 SHALL have port busy, output, 1: pass in progress.
REQ-015 SHALL have port done, output, 1: last pass completed.

Function
REQ-016 SHALL implement FSM states IDLE, WRITE, DONE.
- IDLE->WRITE on start.
- WRITE->DONE on grant with addr==DEPTH-1.
- WRITE->IDLE on abort.
- DONE->WRITE on start.
- Otherwise hold state.
REQ-017 SHALL, on start acceptance in IDLE or DONE, latch mode and fill_value, clear done and load addr=0, with the first write possible the next cycle.
REQ-018 SHALL ignore start while in WRITE; latched mode and fill_value stay unchanged.
REQ-019 SHALL drive wren = (state==WRITE) && grant && !abort, combinationally.
REQ-020 SHALL increment addr by 1 only on a cycle where wren is high.
- addr holds while grant is low (stall).
- Stalls have unbounded length with no data loss.
REQ-021 SHALL drive wrdata from the latched mode:
- 0 IDENTITY: addr zero-extended/truncated to DATA_W.
- 1 REVERSE: DEPTH-1-addr, truncated to DATA_W.
- 2 FILL: latched fill_value.
- 3: treated as IDENTITY.
REQ-022 SHALL write exactly DEPTH words per completed pass, addresses 0..DEPTH-1 ascending, each exactly once.
REQ-023 SHALL leave addr at DEPTH-1 in DONE; it SHALL never wrap to 0 except on new start or reset.
REQ-024 SHALL assert busy iff state==WRITE.
REQ-025 SHALL assert done iff state==DONE; done is held until the next accepted start or reset.
REQ-026 SHALL give abort priority over grant in the same cycle: no write, ->IDLE, done stays 0, addr reset to 0.
REQ-027 SHALL treat abort outside WRITE as no effect.
REQ-028 SHALL give minimum pass latency with grant held high of DEPTH+1 cycles from the start edge to done high.

Reset
REQ-029 SHALL, while reset_n low at a clock edge, force state IDLE, addr 0, latched mode 0, latched fill_value 0.
REQ-030 SHALL hold outputs wren 0, busy 0, done 0 and wrdata 0 during and after reset until start.
REQ-031 SHALL abandon a pass on reset mid-pass without further writes; reset overrides start and abort.

Structure
REQ-032 SHALL place the mode enum (IDENTITY, REVERSE, FILL, RSVD) and state enum in shared package sbox_init_pkg.
REQ-033 SHALL isolate the address counter (load-zero, enable, terminal-count flag) as sub-module sbox_init_ctr, parameterised by ADDR_W and DEPTH.

Verification
REQ-034 SHALL cover: DEPTH=256, mode 0, grant=1, start pulse -> 256 writes S[i]=i, done high at cycle 257 after start and held.
REQ-035 SHALL cover: DEPTH=256, mode 1 -> addr 0 data 255, addr 255 data 0.
REQ-036 SHALL cover: DEPTH=10, mode 2, fill_value 0xA5 -> 10 writes of 0xA5 to addresses 0..9, addr ends 9.
REQ-037 SHALL cover: grant toggling 1-0-0-1 pattern -> no address skipped or repeated; 256 writes total.
REQ-038 SHALL cover: abort at addr 100 with grant=1 -> no write at 100, busy 0, done 0; new start rewrites from addr 0.
REQ-039 SHALL cover: reset_n low at addr 50, and start in DONE -> all outputs 0 after reset; done clears and a full new pass runs.
